// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/exec/write-back control FSM
// Drives IMEM fetch, decoder instruction register and regfile/ALU strobes.
module instr_sequencer #(
  parameter int PC_W     = 8,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_imem_req,
  output logic [PC_W-1:0]  o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [15:0]      i_imem_data,
  output logic [15:0]      o_instr,
  input  logic             i_dec_valid,
  input  logic             i_dec_imm,
  output logic             o_rf_rd_en,
  output logic             o_alu_sel_imm,
  output logic             o_alu_latch,
  output logic             o_rf_wr_en,
  output logic [PC_W-1:0]  o_pc,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic             o_busy,
  output logic             o_illegal,
  output logic             o_timeout
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PC_W-1:0]    r_pc;
  logic [15:0]        r_instr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_illegal;
  logic               r_timeout;
  logic               r_stop_pend;

  logic w_parked;
  logic w_start_go;
  logic w_wait_last;
  logic w_timeout_hit;
  logic w_stop_now;

  assign w_parked      = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR);
  assign w_start_go    = w_parked && i_start;
  assign w_wait_last   = (r_wait == WAIT_W'(MAX_WAIT - 1));
  assign w_timeout_hit = (r_state == S_FETCH) && !i_imem_ack && w_wait_last;
  assign w_stop_now    = r_stop_pend || i_stop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT, S_ERR: begin
        if (i_start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_ack)         w_next = S_DECODE;
        else if (w_timeout_hit) w_next = S_ERR;
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (i_dec_valid) w_next = S_WRITE;
        else             w_next = S_HALT;
      end
      S_WRITE: begin
        if (w_stop_now) w_next = S_IDLE;
        else            w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the current state; the EXEC-phase ALU controls
  // additionally qualify on the decoder outputs registered during DECODE.
  always_comb begin
    o_imem_req    = 1'b0;
    o_rf_rd_en    = 1'b0;
    o_alu_sel_imm = 1'b0;
    o_alu_latch   = 1'b0;
    o_rf_wr_en    = 1'b0;
    o_busy        = !w_parked;
    case (r_state)
      S_FETCH:  o_imem_req = 1'b1;
      S_DECODE: o_rf_rd_en = 1'b1;
      S_EXEC: begin
        o_alu_latch   = i_dec_valid;
        o_alu_sel_imm = i_dec_valid && i_dec_imm;
      end
      S_WRITE:  o_rf_wr_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= '0;
      r_instr     <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
      r_stop_pend <= 1'b0;
    end else if (w_start_go) begin
      r_pc        <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      if (!w_parked && i_stop) r_stop_pend <= 1'b1;
      case (r_state)
        S_FETCH: begin
          if (i_imem_ack) begin
            r_instr <= i_imem_data;
            r_wait  <= '0;
          end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
            r_wait    <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_EXEC: begin
          if (!i_dec_valid) r_illegal <= 1'b1;
        end
        S_WRITE: begin
          // A STOP seen here is consumed by the IDLE transition, so clearing wins.
          r_pc        <= r_pc + PC_W'(1);
          r_stop_pend <= 1'b0;
          if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_imem_addr = r_pc;
  assign o_pc        = r_pc;
  assign o_instr     = r_instr;
  assign o_instr_cnt = r_cnt;
  assign o_illegal   = r_illegal;
  assign o_timeout   = r_timeout;

endmodule
